// File: rtl/cpu_ctrl_pkg.sv
// Shared opcodes, state encoding and instruction field positions for the
// multi-cycle CPU controller.
package cpu_ctrl_pkg;

    localparam int unsigned CNT_W   = 16;
    localparam int unsigned OPC_W   = 2;
    localparam int unsigned INSTR_W = 8;
    localparam int unsigned ST_W    = 3;

    localparam int unsigned OPC_MSB = 7;
    localparam int unsigned OPC_LSB = 6;
    localparam int unsigned RS_MSB  = 5;
    localparam int unsigned RS_LSB  = 4;
    localparam int unsigned RT_MSB  = 3;
    localparam int unsigned RT_LSB  = 2;
    localparam int unsigned IMM_MSB = 1;
    localparam int unsigned IMM_LSB = 0;

    localparam logic [OPC_W-1:0] OP_ADD = 2'b00;
    localparam logic [OPC_W-1:0] OP_LW  = 2'b01;
    localparam logic [OPC_W-1:0] OP_SW  = 2'b10;
    localparam logic [OPC_W-1:0] OP_JMP = 2'b11;

    typedef enum logic [ST_W-1:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    function automatic logic [OPC_W-1:0] get_opcode(input logic [INSTR_W-1:0] instr);
        return instr[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/cpu_instr_dec.sv
// Opcode decoder: classifies the IR contents and flags instructions that
// consume the sign-extended immediate.
module cpu_instr_dec
    import cpu_ctrl_pkg::*;
(
    input  logic [INSTR_W-1:0] instr,
    output logic               is_add,
    output logic               is_lw,
    output logic               is_sw,
    output logic               is_jmp,
    output logic               uses_imm
);

    logic [OPC_W-1:0] w_opc;
    logic             w_unused_fields;

    assign w_opc           = get_opcode(instr);
    // Register and immediate fields feed the datapath directly, not the controller.
    assign w_unused_fields = ^instr[RS_MSB:IMM_LSB];

    assign is_add   = (w_opc == OP_ADD);
    assign is_lw    = (w_opc == OP_LW);
    assign is_sw    = (w_opc == OP_SW);
    assign is_jmp   = (w_opc == OP_JMP);
    assign uses_imm = is_lw | is_sw | is_jmp;

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle control unit: FETCH/DECODE/EXEC/MEM/WB sequencing, datapath
// enables and retired-instruction counter. Optional CTRL_STEP_EN adds HALT.
module cpu_ctrl_fsm
    import cpu_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [INSTR_W-1:0]   instr,
    input  logic                 mem_ready,
    input  logic                 step,
    output logic                 ir_load,
    output logic                 pc_inc,
    output logic                 pc_load,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 iord,
    output logic                 alu_src,
    output logic                 reg_write,
    output logic                 mem_to_reg,
    output logic                 reg_dst,
    output logic                 se_clear,
    output logic                 retire,
    output logic [CNT_W-1:0]     instr_count
);

`ifdef CTRL_STEP_EN
    localparam state_t ST_IDLE = ST_HALT;
`else
    localparam state_t ST_IDLE = ST_FETCH;
    logic w_unused_step;
    assign w_unused_step = step;
`endif

    state_t           r_state;
    logic [CNT_W-1:0] r_instr_count;
    logic             w_is_add;
    logic             w_is_lw;
    logic             w_is_sw;
    logic             w_is_jmp;
    logic             w_uses_imm;

    cpu_instr_dec u_dec (
        .instr    (instr),
        .is_add   (w_is_add),
        .is_lw    (w_is_lw),
        .is_sw    (w_is_sw),
        .is_jmp   (w_is_jmp),
        .uses_imm (w_uses_imm)
    );

    // State sequencing and retire counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_instr_count <= '0;
        end else begin
            r_instr_count <= r_instr_count + CNT_W'(retire);
            case (r_state)
                ST_FETCH:  if (mem_ready) r_state <= ST_DECODE;
                ST_DECODE: r_state <= ST_EXEC;
                ST_EXEC: begin
                    if (w_is_jmp)      r_state <= ST_IDLE;
                    else if (w_is_add) r_state <= ST_WB;
                    else               r_state <= ST_MEM;
                end
                ST_MEM:    if (mem_ready) r_state <= w_is_lw ? ST_WB : ST_IDLE;
                ST_WB:     r_state <= ST_IDLE;
`ifdef CTRL_STEP_EN
                ST_HALT:   if (step) r_state <= ST_FETCH;
`endif
                default:   r_state <= ST_FETCH;
            endcase
        end
    end

    // Enables decode combinationally from state; reset forces the fetch address setup only.
    always_comb begin
        ir_load    = 1'b0;
        pc_inc     = 1'b0;
        pc_load    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        iord       = 1'b0;
        alu_src    = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        reg_dst    = 1'b0;
        se_clear   = 1'b1;
        retire     = 1'b0;
        if (reset) begin
            mem_read = 1'b1;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    mem_read = 1'b1;
                    ir_load  = mem_ready;
                    pc_inc   = mem_ready;
                end
                ST_EXEC: begin
                    se_clear = !w_uses_imm;
                    alu_src  = w_is_lw | w_is_sw;
                    pc_load  = w_is_jmp;
                    retire   = w_is_jmp;
                end
                ST_MEM: begin
                    iord      = 1'b1;
                    alu_src   = 1'b1;
                    se_clear  = 1'b0;
                    mem_read  = w_is_lw;
                    mem_write = w_is_sw;
                    retire    = w_is_sw & mem_ready;
                end
                ST_WB: begin
                    reg_write  = 1'b1;
                    reg_dst    = w_is_add;
                    mem_to_reg = w_is_lw;
                    retire     = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign instr_count = r_instr_count;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Directed self-checking bench for cpu_ctrl_fsm; output vector order is
// {ir_load,pc_inc,pc_load,mem_read,mem_write,iord,alu_src,reg_write,mem_to_reg,reg_dst,se_clear,retire}.
module tb_cpu_ctrl_fsm;
    import cpu_ctrl_pkg::*;

    localparam logic [11:0] O_RESET      = 12'h102;
    localparam logic [11:0] O_FETCH_RDY  = 12'hD02;
    localparam logic [11:0] O_FETCH_WAIT = 12'h102;
    localparam logic [11:0] O_QUIET      = 12'h002;
    localparam logic [11:0] O_WB_ADD     = 12'h017;
    localparam logic [11:0] O_EXEC_MEM   = 12'h020;
    localparam logic [11:0] O_MEM_LW     = 12'h160;
    localparam logic [11:0] O_WB_LW      = 12'h01B;
    localparam logic [11:0] O_MEM_SW_RDY = 12'h0E1;
    localparam logic [11:0] O_MEM_SW_WT  = 12'h0E0;
    localparam logic [11:0] O_EXEC_JMP   = 12'h201;

    localparam logic [7:0] I_ADD = 8'b00_01_10_11;
    localparam logic [7:0] I_LW  = 8'b01_01_10_11;
    localparam logic [7:0] I_SW  = 8'b10_01_10_00;
    localparam logic [7:0] I_JMP = 8'b11_00_00_10;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  instr;
    logic        mem_ready;
    logic        step;
    logic        ir_load, pc_inc, pc_load, mem_read, mem_write, iord;
    logic        alu_src, reg_write, mem_to_reg, reg_dst, se_clear, retire;
    logic [15:0] instr_count;
    logic [11:0] w_outs;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign w_outs = {ir_load, pc_inc, pc_load, mem_read, mem_write, iord,
                     alu_src, reg_write, mem_to_reg, reg_dst, se_clear, retire};

    cpu_ctrl_fsm dut (
        .clk         (clk),
        .reset       (reset),
        .instr       (instr),
        .mem_ready   (mem_ready),
        .step        (step),
        .ir_load     (ir_load),
        .pc_inc      (pc_inc),
        .pc_load     (pc_load),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .iord        (iord),
        .alu_src     (alu_src),
        .reg_write   (reg_write),
        .mem_to_reg  (mem_to_reg),
        .reg_dst     (reg_dst),
        .se_clear    (se_clear),
        .retire      (retire),
        .instr_count (instr_count)
    );

    task automatic apply_reset();
        reset = 1'b1;
        mem_ready = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [11:0] exp_idle;
        reset = 1'b1; mem_ready = 1'b1; step = 1'b0; instr = I_ADD;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (w_outs !== O_RESET) begin
            errors++;
            $display("FAIL reset_outputs: outs=%h expected %h", w_outs, O_RESET);
        end
        checks++;
        if (instr_count !== 16'h0000) begin
            errors++;
            $display("FAIL reset_count: count=%h expected 0000", instr_count);
        end
        reset = 1'b0; mem_ready = 1'b0;
        @(posedge clk); #1;
`ifdef CTRL_STEP_EN
        exp_idle = O_QUIET;
`else
        exp_idle = O_FETCH_WAIT;
`endif
        checks++;
        if (w_outs !== exp_idle) begin
            errors++;
            $display("FAIL reset_exit_state: outs=%h expected %h", w_outs, exp_idle);
        end
    endtask

`ifdef CTRL_STEP_EN
    task automatic test_step();
        logic [11:0] exp [4] = '{O_FETCH_RDY, O_QUIET, O_QUIET, O_WB_ADD};
        apply_reset();
        instr = I_ADD; mem_ready = 1'b1; step = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++;
            if (w_outs !== O_QUIET) begin
                errors++;
                $display("FAIL step_halt_wait cyc %0d: outs=%h expected %h", i, w_outs, O_QUIET);
            end
            @(posedge clk); #1;
        end
        step = 1'b1;
        @(posedge clk); #1;
        step = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (w_outs !== exp[i]) begin
                errors++;
                $display("FAIL step_add step %0d: outs=%h expected %h", i, w_outs, exp[i]);
            end
            @(posedge clk); #1;
        end
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (w_outs !== O_QUIET) begin
                errors++;
                $display("FAIL step_rehalt cyc %0d: outs=%h expected %h", i, w_outs, O_QUIET);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (instr_count !== 16'h0001) begin
            errors++;
            $display("FAIL step_count: count=%h expected 0001", instr_count);
        end
    endtask
`else
    task automatic test_add();
        logic [11:0] exp [4] = '{O_FETCH_RDY, O_QUIET, O_QUIET, O_WB_ADD};
        instr = I_ADD;
        for (int i = 0; i < 4; i++) begin
            mem_ready = 1'b1; #1;
            checks++;
            if (w_outs !== exp[i]) begin
                errors++;
                $display("FAIL add step %0d: outs=%h expected %h", i, w_outs, exp[i]);
            end
            @(posedge clk); #1;
        end
        mem_ready = 1'b0; #1;
        checks++;
        if (instr_count !== 16'h0001) begin
            errors++;
            $display("FAIL add_count: count=%h expected 0001", instr_count);
        end
    endtask

    task automatic test_lw();
        logic        rdy [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [11:0] exp [7] = '{O_FETCH_RDY, O_QUIET, O_EXEC_MEM, O_MEM_LW,
                                 O_MEM_LW, O_MEM_LW, O_WB_LW};
        instr = I_LW;
        for (int i = 0; i < 7; i++) begin
            mem_ready = rdy[i]; #1;
            checks++;
            if (w_outs !== exp[i]) begin
                errors++;
                $display("FAIL lw step %0d: outs=%h expected %h", i, w_outs, exp[i]);
            end
            @(posedge clk); #1;
        end
        mem_ready = 1'b0; #1;
        checks++;
        if (instr_count !== 16'h0002) begin
            errors++;
            $display("FAIL lw_count: count=%h expected 0002", instr_count);
        end
    endtask

    task automatic test_sw_jmp();
        logic [7:0]  ins [7] = '{I_SW, I_SW, I_SW, I_SW, I_JMP, I_JMP, I_JMP};
        logic [11:0] exp [7] = '{O_FETCH_RDY, O_QUIET, O_EXEC_MEM, O_MEM_SW_RDY,
                                 O_FETCH_RDY, O_QUIET, O_EXEC_JMP};
        apply_reset();
        for (int i = 0; i < 7; i++) begin
            instr = ins[i]; mem_ready = 1'b1; #1;
            checks++;
            if (w_outs !== exp[i]) begin
                errors++;
                $display("FAIL sw_jmp step %0d: outs=%h expected %h", i, w_outs, exp[i]);
            end
            @(posedge clk); #1;
        end
        mem_ready = 1'b0; #1;
        checks++;
        if (w_outs !== O_FETCH_WAIT) begin
            errors++;
            $display("FAIL jmp_to_fetch: outs=%h expected %h", w_outs, O_FETCH_WAIT);
        end
        checks++;
        if (instr_count !== 16'h0002) begin
            errors++;
            $display("FAIL sw_jmp_count: count=%h expected 0002", instr_count);
        end
    endtask

    task automatic test_reset_mid();
        logic [11:0] exp [4] = '{O_FETCH_RDY, O_QUIET, O_EXEC_MEM, O_MEM_SW_WT};
        logic        rdy [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        instr = I_SW;
        for (int i = 0; i < 4; i++) begin
            mem_ready = rdy[i]; #1;
            checks++;
            if (w_outs !== exp[i]) begin
                errors++;
                $display("FAIL reset_mid step %0d: outs=%h expected %h", i, w_outs, exp[i]);
            end
            if (i < 3) begin
                @(posedge clk); #1;
            end
        end
        reset = 1'b1; mem_ready = 1'b1; #1;
        checks++;
        if (w_outs !== O_RESET) begin
            errors++;
            $display("FAIL reset_mid_in_reset: outs=%h expected %h", w_outs, O_RESET);
        end
        @(posedge clk); #1;
        reset = 1'b0; mem_ready = 1'b0; #1;
        checks++;
        if (w_outs !== O_FETCH_WAIT) begin
            errors++;
            $display("FAIL reset_mid_fetch: outs=%h expected %h", w_outs, O_FETCH_WAIT);
        end
        checks++;
        if (instr_count !== 16'h0000) begin
            errors++;
            $display("FAIL reset_mid_count: count=%h expected 0000", instr_count);
        end
    endtask

    task automatic test_wrap();
        logic [11:0] exp [4] = '{O_FETCH_RDY, O_QUIET, O_QUIET, O_WB_ADD};
        mem_ready = 1'b0;
        force dut.r_instr_count = 16'hFFFF;
        @(posedge clk); #1;
        release dut.r_instr_count;
        #1;
        checks++;
        if (instr_count !== 16'hFFFF) begin
            errors++;
            $display("FAIL wrap_preload: count=%h expected ffff", instr_count);
        end
        instr = I_ADD;
        for (int i = 0; i < 4; i++) begin
            mem_ready = 1'b1; #1;
            checks++;
            if (w_outs !== exp[i]) begin
                errors++;
                $display("FAIL wrap_add step %0d: outs=%h expected %h", i, w_outs, exp[i]);
            end
            @(posedge clk); #1;
        end
        mem_ready = 1'b0; #1;
        checks++;
        if (instr_count !== 16'h0000) begin
            errors++;
            $display("FAIL wrap_count: count=%h expected 0000", instr_count);
        end
    endtask
`endif

    initial begin
        reset = 1'b1; mem_ready = 1'b0; step = 1'b0; instr = 8'h00;
        test_reset();
`ifdef CTRL_STEP_EN
        test_step();
`else
        test_add();
        test_lw();
        test_sw_jmp();
        test_reset_mid();
        test_wrap();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
